// File: rtl/rvvi_pkg.sv
// Shared types and helpers for the RVVI replay buffer: FSM state, default widths,
// and the wrap-aware sequence-number comparison.
package rvvi_pkg;

   typedef enum logic {
      STREAM = 1'b0,
      REPLAY = 1'b1
   } replay_state_t;

   localparam int unsigned DEF_DEPTH   = 8;
   localparam int unsigned DEF_WIDTH   = 792;
   localparam int unsigned DEF_SEQ_W   = 32;
   localparam logic [31:0] DEF_TIMEOUT = 32'd1000000;
   localparam int unsigned SEQ_MAX_W   = 64;

   // True when a is strictly newer than b in a w-bit wrapping sequence space,
   // i.e. the w-bit difference a-b is non-zero with its sign bit clear.
   function automatic logic seq_newer(input logic [SEQ_MAX_W-1:0] a,
                                      input logic [SEQ_MAX_W-1:0] b,
                                      input int unsigned          w);
      logic [SEQ_MAX_W-1:0] mask;
      logic [SEQ_MAX_W-1:0] msb;
      logic [SEQ_MAX_W-1:0] diff;
      mask = (SEQ_MAX_W'(1) << w) - SEQ_MAX_W'(1);
      msb  = SEQ_MAX_W'(1) << (w - 1);
      diff = (a - b) & mask;
      return (diff != '0) && ((diff & msb) == '0);
   endfunction

endpackage

// File: rtl/rvvi_replay_ram.sv
// Record store for the replay buffer: one write port, an async read port for the
// offer pointer and a seq-only async read port for the oldest entry.
module rvvi_replay_ram
   import rvvi_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SEQ_W = DEF_SEQ_W,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [SEQ_W-1:0] wr_seq,
   input  logic [AW-1:0]    send_addr,
   output logic [WIDTH-1:0] send_data,
   input  logic [AW-1:0]    head_addr,
   output logic [SEQ_W-1:0] head_seq
);

   logic [WIDTH+SEQ_W-1:0] mem_q [DEPTH];

   // No reset: contents are only ever read between head and tail.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= {wr_data, wr_seq};
   end

   assign send_data = mem_q[send_addr][WIDTH+SEQ_W-1:SEQ_W];
   assign head_seq  = mem_q[head_addr][SEQ_W-1:0];

endmodule

// File: rtl/rvvi_replay_buffer.sv
// Lossless RVVI trace buffer: holds records until cumulatively acked, replays on NACK
// or ack timeout, and stalls the CPU. Event counters built with RVVI_REPLAY_STATS_EN.
module rvvi_replay_buffer
   import rvvi_pkg::*;
#(
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned SEQ_W   = DEF_SEQ_W,
   parameter logic [31:0] TIMEOUT = DEF_TIMEOUT
) (
   input  logic                       m_axi_aclk,
   input  logic                       m_axi_aresetn,
   input  logic                       InValid,
   input  logic [WIDTH-1:0]           InData,
   input  logic [SEQ_W-1:0]           InSeq,
   input  logic                       AckValid,
   input  logic [SEQ_W-1:0]           AckSeq,
   input  logic                       NackValid,
   output logic                       OutValid,
   output logic [WIDTH-1:0]           OutData,
   input  logic                       OutReady,
   output logic                       OutReplay,
   output logic [$clog2(DEPTH+1)-1:0] Occupancy,
   output logic                       Full,
   output logic                       Overflow,
   output logic                       ExternalStall,
   output logic [31:0]                ReplayEvents,
   output logic [31:0]                TimeoutEvents
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PW    = AW + 1;
   localparam int unsigned SEQ_L = SEQ_W;

   logic [PW-1:0]    head_q, head_d, send_q, send_d, tail_q, tail_d, rend_q, rend_d;
   logic [PW-1:0]    send_inc, occ;
   logic [SEQ_W-1:0] last_ack_q, last_ack_d, head_seq;
   logic [31:0]      timer_q, timer_d;
   replay_state_t    state_q, state_d;
   logic             overflow_q, overflow_d;
   logic             full, wr_en, hs, retire, repl_go, tmo_go;

   rvvi_replay_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEQ_W(SEQ_W)) u_ram (
      .clk       (m_axi_aclk),
      .wr_en     (wr_en),
      .wr_addr   (tail_q[AW-1:0]),
      .wr_data   (InData),
      .wr_seq    (InSeq),
      .send_addr (send_q[AW-1:0]),
      .send_data (OutData),
      .head_addr (head_q[AW-1:0]),
      .head_seq  (head_seq)
   );

   assign occ      = tail_q - head_q;
   assign full     = (occ == PW'(DEPTH));
   assign wr_en    = InValid && !full;
   assign OutValid = (send_q != tail_q);
   assign hs       = OutValid && OutReady;
   assign send_inc = send_q + PW'(hs);
   assign retire   = (head_q != send_q) &&
                     !seq_newer(SEQ_MAX_W'(head_seq), SEQ_MAX_W'(last_ack_q), SEQ_L);

   always_comb begin
      head_d     = head_q + PW'(retire);
      tail_d     = tail_q + PW'(wr_en);
      send_d     = send_inc;
      rend_d     = rend_q;
      state_d    = state_q;
      overflow_d = overflow_q | (InValid & full);
      last_ack_d = last_ack_q;
      repl_go    = 1'b0;
      tmo_go     = 1'b0;
      if (AckValid && seq_newer(SEQ_MAX_W'(AckSeq), SEQ_MAX_W'(last_ack_q), SEQ_L))
         last_ack_d = AckSeq;

      if (retire || (head_q == send_q))
         timer_d = '0;
      else if (timer_q != TIMEOUT)
         timer_d = timer_q + 32'd1;
      else
         timer_d = timer_q;

      // Rewinding to head_d (not head_q) keeps head <= send if an entry retires this cycle.
      case (state_q)
         STREAM: begin
            if ((NackValid || (timer_q == TIMEOUT)) && (head_q != send_q) &&
                (head_d != send_inc)) begin
               state_d = REPLAY;
               rend_d  = send_inc;
               send_d  = head_d;
               timer_d = '0;
               repl_go = 1'b1;
               tmo_go  = !NackValid;
            end
         end
         REPLAY: begin
            if (NackValid && (head_q != send_q)) begin
               send_d  = head_d;
               repl_go = 1'b1;
               if (head_d == rend_q) state_d = STREAM;
            end else if (hs && (send_inc == rend_q)) begin
               state_d = STREAM;
            end
         end
         default: state_d = STREAM;
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         head_q     <= '0;
         send_q     <= '0;
         tail_q     <= '0;
         rend_q     <= '0;
         last_ack_q <= '0;
         timer_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= STREAM;
      end else begin
         head_q     <= head_d;
         send_q     <= send_d;
         tail_q     <= tail_d;
         rend_q     <= rend_d;
         last_ack_q <= last_ack_d;
         timer_q    <= timer_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
      end
   end

   assign OutReplay     = (state_q == REPLAY);
   assign Occupancy     = occ;
   assign Full          = full;
   assign Overflow      = overflow_q;
   // Combinational so the CPU is held off before a write could be dropped.
   assign ExternalStall = full | ((occ == PW'(DEPTH - 1)) & InValid) | (state_q == REPLAY);

`ifdef RVVI_REPLAY_STATS_EN
   logic [31:0] replay_cnt_q, replay_cnt_d, timeout_cnt_q, timeout_cnt_d;

   always_comb begin
      replay_cnt_d  = replay_cnt_q + {31'b0, repl_go};
      timeout_cnt_d = timeout_cnt_q + {31'b0, tmo_go};
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         replay_cnt_q  <= '0;
         timeout_cnt_q <= '0;
      end else begin
         replay_cnt_q  <= replay_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

   assign ReplayEvents  = replay_cnt_q;
   assign TimeoutEvents = timeout_cnt_q;
`else
   logic unused_stats;
   assign unused_stats  = repl_go ^ tmo_go;
   assign ReplayEvents  = '0;
   assign TimeoutEvents = '0;
`endif

endmodule
